am_dac_sequencer: RTL and testbench
===================================

Name: am_dac_sequencer

Overview:
- Controller that drives the AM_DAC's distance and enable inputs.
- Accepts distance samples from the ranging front end over a valid/ready handshake.
- Applies new samples only at sine-period boundaries, so the carrier never changes amplitude mid-cycle.
- Slews amplitude in bounded steps, and ramps the DAC down then disables it when samples go stale or the run request drops.

Parameters:
WIDTH, 13, bit width of distance samples and dac_distance
LOG2_MAX_DIST, 11, log2 of maximum distance
MAX_DIST, 2**LOG2_MAX_DIST, clamp ceiling for target distance
RAMP_STEP, 64, max change of dac_distance per period boundary; 0 = jump directly to target
STALE_CYCLES, 2**21, clock cycles without an accepted sample before forced shutdown
STALE_WIDTH, $clog2(STALE_CYCLES+1), width of stale counter

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
run  input  1  level request to operate the DAC
sample_valid  input  1  sample_data valid
sample_data  input  WIDTH  raw distance sample
sample_ready  output  1  sequencer can accept a sample this cycle
period_done  input  1  single-cycle pulse from AM_DAC at sine-period wrap
dac_enable  output  1  to AM_DAC enable
dac_distance  output  WIDTH  to AM_DAC distance
muted  output  1  high when dac_enable=0 or dac_distance=0
stale  output  1  sticky flag: shutdown caused by stale timeout; cleared on next IDLE->START

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (reset_n); all state is reset immediately on assertion.
- Reset values: state=IDLE; dac_enable=0; dac_distance=0; sample_ready=0; muted=1; stale=0; pending=0; target=0; stale counter=0.
- All outputs are registered except sample_ready, which is combinational: sample_ready = (state==START || state==ACTIVE) && !pending.
- Accept rule: a sample is accepted when sample_valid && sample_ready. On accept:
  - The sample is stored in pending_data and pending is set.
  - The stale counter clears.
- Clamp rule: target_in = (pending_data > MAX_DIST) ? MAX_DIST : pending_data.
- Step rule, applied on period_done in ACTIVE or DRAIN:
  - If |target - dac_distance| <= RAMP_STEP, or RAMP_STEP==0: dac_distance <= target.
  - Otherwise dac_distance moves toward target by exactly RAMP_STEP.
  - Arithmetic is carried in WIDTH+1 bits; no wrap is permitted.
- States:
  - IDLE: dac_enable=0. If run=1 -> START; stale is cleared on this transition.
  - START: dac_enable=1 (registered, asserted the cycle after entry); dac_distance=0. First accepted sample -> ACTIVE. run=0 -> IDLE.
  - ACTIVE: on period_done, if pending is set, target <= target_in and pending clears. dac_distance steps toward the updated target in the same cycle. Stale counter increments each cycle there is no accept.
  - ACTIVE exits: run=0 -> DRAIN; stale counter reaching STALE_CYCLES -> DRAIN with stale=1. In both cases target is forced to 0 and pending is discarded.
  - DRAIN: sample_ready=0. dac_distance steps toward 0 on each period_done. On a period_done where dac_distance is already 0 -> IDLE; dac_enable falls the following cycle.
- Simultaneous accept and period_done (pending empty): the new sample becomes pending and is not applied until the next period_done.
- period_done while pending is empty: the step continues toward the existing target.
- run reasserted during DRAIN is ignored. Re-entry is only via IDLE->START, which adds one cycle of idle.
- period_done in IDLE or START is ignored.
- Stale counter saturates and only counts in ACTIVE.
- Reset mid-ramp: outputs return to reset values immediately; no drain is performed.

Test Plan:
Bench setup: STALE_CYCLES=1000, RAMP_STEP=64; bench pulses period_done every 50 cycles.
1. Ramp up: run=1, sample 500 -> dac_enable=1; dac_distance goes 0,64,128,...,448,500 on successive period_done pulses (8 pulses); muted falls after the first pulse.
2. Clamp: in ACTIVE, send sample 3000 -> target=2048; dac_distance rises by 64 per pulse and settles at exactly 2048, never above.
3. Backpressure: two samples 800 then 200 sent back-to-back between pulses -> sample_ready low after the first; 800 is applied at the next pulse; 200 is accepted after that pulse and applied at the following one.
4. Stale shutdown: at dac_distance=256, stop samples for 1000 cycles -> DRAIN; steps 192,128,64,0; IDLE on the next pulse; dac_enable=0 the cycle after; stale=1 until run restarts.
5. run deassert plus reset: drop run at dac_distance=128 -> ramps to 0, IDLE, stale=0. Repeat, asserting reset_n=0 mid-ramp -> all outputs at reset values without waiting for clk.
6. RAMP_STEP=0: sample 1500 -> dac_distance jumps 0->1500 on the first period_done.

Source files
------------

// File: rtl/am_dac_sequencer.sv
// Purpose: paces ranging distance samples into the AM_DAC at sine-period boundaries, slewing amplitude and ramping down on stop/stale.
// Latency: a sample accepted before a period_done is applied on that period_done; all outputs registered except sample_ready.
// Backpressure: one-entry pending buffer; sample_ready is low while a sample is pending or outside START/ACTIVE.
module am_dac_sequencer #(
  parameter int WIDTH         = 13,
  parameter int LOG2_MAX_DIST = 11,
  parameter int MAX_DIST      = 2**LOG2_MAX_DIST,
  parameter int RAMP_STEP     = 64,
  parameter int STALE_CYCLES  = 2**21,
  parameter int STALE_WIDTH   = $clog2(STALE_CYCLES+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_data,
  output logic             sample_ready,
  input  logic             period_done,
  output logic             dac_enable,
  output logic [WIDTH-1:0] dac_distance,
  output logic             muted,
  output logic             stale
);

  typedef enum logic [1:0] {IDLE, START, ACTIVE, DRAIN} state_t;

  localparam logic [WIDTH-1:0]       MAX_DIST_W  = MAX_DIST[WIDTH-1:0];
  localparam logic [WIDTH:0]         STEP_W      = RAMP_STEP[WIDTH:0];
  localparam logic [STALE_WIDTH-1:0] STALE_LIMIT = STALE_CYCLES[STALE_WIDTH-1:0];

  state_t                 state_q, state_d;
  logic                   pending_q, pending_d;
  logic [WIDTH-1:0]       pending_data_q, pending_data_d;
  logic [WIDTH-1:0]       target_q, target_d;
  logic [WIDTH-1:0]       dist_d;
  logic                   enable_d;
  logic                   muted_d;
  logic                   stale_d;
  logic [STALE_WIDTH-1:0] stale_cnt_q, stale_cnt_d;
  logic                   accept;
  logic [WIDTH-1:0]       target_in;
  logic                   stale_hit;

  // Move cur toward tgt by at most RAMP_STEP; the extra top bit keeps the difference from wrapping.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
    logic [WIDTH:0] c;
    logic [WIDTH:0] t;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    diff = (t >= c) ? (t - c) : (c - t);
    if (RAMP_STEP == 0 || diff <= STEP_W) begin
      r = t;
    end else if (t > c) begin
      r = c + STEP_W;
    end else begin
      r = c - STEP_W;
    end
    return r[WIDTH-1:0];
  endfunction

  assign sample_ready = (state_q == START || state_q == ACTIVE) && !pending_q;
  assign accept       = sample_valid && sample_ready;
  assign target_in    = (pending_data_q > MAX_DIST_W) ? MAX_DIST_W : pending_data_q;
  assign stale_hit    = (stale_cnt_q == STALE_LIMIT);

  // Next-state, sample capture, target update and amplitude stepping.
  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    pending_data_d = pending_data_q;
    target_d       = target_q;
    dist_d         = dac_distance;
    stale_d        = stale;
    stale_cnt_d    = stale_cnt_q;

    if (accept) begin
      pending_d      = 1'b1;
      pending_data_d = sample_data;
    end

    case (state_q)
      IDLE: begin
        dist_d      = '0;
        target_d    = '0;
        pending_d   = 1'b0;
        stale_cnt_d = '0;
        if (run) begin
          state_d = START;
          stale_d = 1'b0;
        end
      end
      START: begin
        dist_d      = '0;
        stale_cnt_d = '0;
        if (!run) begin
          state_d   = IDLE;
          pending_d = 1'b0;
        end else if (accept) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (accept) begin
          stale_cnt_d = '0;
        end else if (!stale_hit) begin
          stale_cnt_d = stale_cnt_q + STALE_WIDTH'(1);
        end
        if (!run || stale_hit) begin
          // Shutting down: aim for zero and drop whatever is waiting.
          state_d   = DRAIN;
          target_d  = '0;
          pending_d = 1'b0;
          if (stale_hit) begin
            stale_d = 1'b1;
          end
        end else if (period_done && pending_q) begin
          target_d  = target_in;
          pending_d = 1'b0;
        end
        if (period_done) begin
          dist_d = step_toward(dac_distance, target_d);
        end
      end
      DRAIN: begin
        if (period_done) begin
          if (dac_distance == '0) begin
            state_d = IDLE;
          end else begin
            dist_d = step_toward(dac_distance, '0);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Enable trails the state by one cycle on both entry to START and return to IDLE.
    enable_d = (state_q != IDLE);
    muted_d  = !enable_d || (dist_d == '0);
  end

  // State and output registers; reset clears everything immediately, no drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      pending_q      <= 1'b0;
      pending_data_q <= '0;
      target_q       <= '0;
      dac_distance   <= '0;
      dac_enable     <= 1'b0;
      muted          <= 1'b1;
      stale          <= 1'b0;
      stale_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      pending_data_q <= pending_data_d;
      target_q       <= target_d;
      dac_distance   <= dist_d;
      dac_enable     <= enable_d;
      muted          <= muted_d;
      stale          <= stale_d;
      stale_cnt_q    <= stale_cnt_d;
    end
  end

endmodule

// File: tb/tb_am_dac_sequencer.sv
// Directed bench for am_dac_sequencer: ramp, clamp, backpressure, stale shutdown, run drop, reset, zero step.
// Inputs and checks happen on the falling edge; period_done pulses once every 50 cycles.
// A second instance with RAMP_STEP=0 covers the direct-jump case.
module tb_am_dac_sequencer;

  logic        clk;
  logic        reset_n;
  logic        period_done;
  logic        run, sample_valid;
  logic [12:0] sample_data;
  logic        sample_ready, dac_enable, muted, stale;
  logic [12:0] dac_distance;
  logic        run2, valid2;
  logic [12:0] data2;
  logic        ready2, en2, muted2, stale2;
  logic [12:0] dist2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  am_dac_sequencer #(.WIDTH(13), .LOG2_MAX_DIST(11), .RAMP_STEP(64), .STALE_CYCLES(1000)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .sample_valid(sample_valid),
    .sample_data(sample_data), .sample_ready(sample_ready), .period_done(period_done),
    .dac_enable(dac_enable), .dac_distance(dac_distance), .muted(muted), .stale(stale)
  );

  am_dac_sequencer #(.WIDTH(13), .LOG2_MAX_DIST(11), .RAMP_STEP(0), .STALE_CYCLES(1000)) dut0 (
    .clk(clk), .reset_n(reset_n), .run(run2), .sample_valid(valid2),
    .sample_data(data2), .sample_ready(ready2), .period_done(period_done),
    .dac_enable(en2), .dac_distance(dist2), .muted(muted2), .stale(stale2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    period_done = 1'b0;
    forever begin
      repeat (49) @(negedge clk);
      period_done = 1'b1;
      @(negedge clk);
      period_done = 1'b0;
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send_sample(input logic [12:0] d);
    bit ok = 0;
    sample_valid = 1'b1;
    sample_data  = d;
    for (int i = 0; i < 200; i++) begin
      if (sample_ready === 1'b1) ok = 1;
      @(negedge clk);
      if (ok) break;
    end
    sample_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout sample %0d never accepted", d);
    end
  endtask

  // Waits for the next rising edge that carries period_done, then to the following falling edge.
  task automatic next_pulse;
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk);
      if (period_done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL pulse_timeout no period_done within 60 cycles");
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dac_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %b exp 0", dac_enable); end
    checks++; if (dac_distance !== 13'd0) begin errors++; $display("FAIL reset_distance got %0d exp 0", dac_distance); end
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", sample_ready); end
    checks++; if (muted !== 1'b1) begin errors++; $display("FAIL reset_muted got %b exp 1", muted); end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL reset_stale got %b exp 0", stale); end
    checks++; if (en2 !== 1'b0 || dist2 !== 13'd0 || muted2 !== 1'b1) begin
      errors++; $display("FAIL reset_dut0 en %b dist %0d muted %b exp 0 0 1", en2, dist2, muted2);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ramp_up;
    int e;
    run = 1'b1;
    @(negedge clk);
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL start_ready got %b exp 1", sample_ready); end
    checks++; if (dac_enable !== 1'b0) begin errors++; $display("FAIL start_enable_delay got %b exp 0", dac_enable); end
    send_sample(13'd500);
    checks++; if (dac_enable !== 1'b1) begin errors++; $display("FAIL start_enable got %b exp 1", dac_enable); end
    checks++; if (muted !== 1'b1 || dac_distance !== 13'd0) begin
      errors++; $display("FAIL prepulse muted %b dist %0d exp 1 0", muted, dac_distance);
    end
    for (int k = 1; k <= 8; k++) begin
      next_pulse();
      e = (64 * k > 500) ? 500 : 64 * k;
      checks++; if (dac_distance !== 13'(e)) begin errors++; $display("FAIL ramp_up step %0d got %0d exp %0d", k, dac_distance, e); end
      if (k == 1) begin
        checks++; if (muted !== 1'b0) begin errors++; $display("FAIL ramp_unmute got %b exp 0", muted); end
      end
    end
  endtask

  task automatic test_clamp;
    int e;
    send_sample(13'd3000);
    for (int k = 1; k <= 25; k++) begin
      next_pulse();
      e = (500 + 64 * k > 2048) ? 2048 : 500 + 64 * k;
      checks++; if (dac_distance !== 13'(e)) begin errors++; $display("FAIL clamp step %0d got %0d exp %0d", k, dac_distance, e); end
      if (k < 25) send_sample(13'd3000);
    end
    next_pulse();
    checks++; if (dac_distance !== 13'd2048) begin errors++; $display("FAIL clamp_hold got %0d exp 2048", dac_distance); end
  endtask

  task automatic test_backpressure;
    send_sample(13'd800);
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b exp 0", sample_ready); end
    sample_valid = 1'b1;
    sample_data  = 13'd200;
    next_pulse();
    checks++; if (dac_distance !== 13'd1984) begin errors++; $display("FAIL bp_apply_800 got %0d exp 1984", dac_distance); end
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_reopen got %b exp 1", sample_ready); end
    @(negedge clk);
    sample_valid = 1'b0;
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL bp_accept_200 ready %b exp 0", sample_ready); end
    next_pulse();
    checks++; if (dac_distance !== 13'd1920) begin errors++; $display("FAIL bp_apply_200 got %0d exp 1920", dac_distance); end
  endtask

  task automatic test_stale;
    int last_acc;
    int n;
    for (int k = 1; k <= 26; k++) begin
      send_sample(13'd256);
      last_acc = cyc;
      next_pulse();
      checks++; if (dac_distance !== 13'(1920 - 64 * k)) begin
        errors++; $display("FAIL descend step %0d got %0d exp %0d", k, dac_distance, 1920 - 64 * k);
      end
    end
    n = 0;
    while (sample_ready === 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (cyc - last_acc < 995 || cyc - last_acc > 1005) begin
      errors++; $display("FAIL stale_timeout drain after %0d cycles exp about 1001", cyc - last_acc);
    end
    checks++; if (stale !== 1'b1 || dac_enable !== 1'b1 || dac_distance !== 13'd256) begin
      errors++; $display("FAIL stale_entry stale %b en %b dist %0d exp 1 1 256", stale, dac_enable, dac_distance);
    end
    run = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      next_pulse();
      checks++; if (dac_distance !== 13'(256 - 64 * k)) begin
        errors++; $display("FAIL drain step %0d got %0d exp %0d", k, dac_distance, 256 - 64 * k);
      end
    end
    next_pulse();
    checks++; if (dac_enable !== 1'b1) begin errors++; $display("FAIL enable_hold got %b exp 1", dac_enable); end
    @(negedge clk);
    checks++; if (dac_enable !== 1'b0 || muted !== 1'b1) begin
      errors++; $display("FAIL enable_fall en %b muted %b exp 0 1", dac_enable, muted);
    end
    repeat (3) @(negedge clk);
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL stale_sticky got %b exp 1", stale); end
  endtask

  task automatic test_run_drop;
    run = 1'b1;
    @(negedge clk);
    checks++; if (stale !== 1'b0 || sample_ready !== 1'b1) begin
      errors++; $display("FAIL restart stale %b ready %b exp 0 1", stale, sample_ready);
    end
    send_sample(13'd128);
    next_pulse();
    checks++; if (dac_distance !== 13'd64) begin errors++; $display("FAIL rd_up1 got %0d exp 64", dac_distance); end
    next_pulse();
    checks++; if (dac_distance !== 13'd128) begin errors++; $display("FAIL rd_up2 got %0d exp 128", dac_distance); end
    run = 1'b0;
    @(negedge clk);
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL rd_drain_ready got %b exp 0", sample_ready); end
    next_pulse();
    checks++; if (dac_distance !== 13'd64) begin errors++; $display("FAIL rd_down1 got %0d exp 64", dac_distance); end
    next_pulse();
    checks++; if (dac_distance !== 13'd0) begin errors++; $display("FAIL rd_down2 got %0d exp 0", dac_distance); end
    next_pulse();
    @(negedge clk);
    checks++; if (dac_enable !== 1'b0 || stale !== 1'b0) begin
      errors++; $display("FAIL rd_idle en %b stale %b exp 0 0", dac_enable, stale);
    end
    // Same again, but pull reset in the middle of the ramp-down.
    run = 1'b1;
    @(negedge clk);
    send_sample(13'd128);
    next_pulse();
    next_pulse();
    checks++; if (dac_distance !== 13'd128) begin errors++; $display("FAIL rr_up got %0d exp 128", dac_distance); end
    run = 1'b0;
    next_pulse();
    checks++; if (dac_distance !== 13'd64 || dac_enable !== 1'b1) begin
      errors++; $display("FAIL rr_mid dist %0d en %b exp 64 1", dac_distance, dac_enable);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (dac_enable !== 1'b0 || dac_distance !== 13'd0 || muted !== 1'b1 || stale !== 1'b0 || sample_ready !== 1'b0) begin
      errors++; $display("FAIL async_reset en %b dist %0d muted %b stale %b ready %b exp 0 0 1 0 0",
                         dac_enable, dac_distance, muted, stale, sample_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (dac_enable !== 1'b0 || dac_distance !== 13'd0) begin
      errors++; $display("FAIL post_reset en %b dist %0d exp 0 0", dac_enable, dac_distance);
    end
  endtask

  task automatic test_ramp_zero;
    run2 = 1'b1;
    @(negedge clk);
    checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL z_ready got %b exp 1", ready2); end
    valid2 = 1'b1;
    data2  = 13'd1500;
    @(negedge clk);
    valid2 = 1'b0;
    checks++; if (en2 !== 1'b1 || dist2 !== 13'd0) begin
      errors++; $display("FAIL z_start en %b dist %0d exp 1 0", en2, dist2);
    end
    next_pulse();
    checks++; if (dist2 !== 13'd1500) begin errors++; $display("FAIL z_jump got %0d exp 1500", dist2); end
    checks++; if (muted2 !== 1'b0) begin errors++; $display("FAIL z_unmute got %b exp 0", muted2); end
  endtask

  initial begin
    reset_n      = 1'b0;
    run          = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    run2         = 1'b0;
    valid2       = 1'b0;
    data2        = '0;
    @(negedge clk);
    test_reset();
    test_ramp_up();
    test_clamp();
    test_backpressure();
    test_stale();
    test_run_drop();
    test_ramp_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
